// File: rtl/dpe_egress_pkt_fifo.sv
// Per-port store-and-forward egress packet FIFO.
// Always accepts input beats, so a stalled MAC never backpressures the demux.
// Packets that do not fit are dropped whole by rolling the write pointer back.
// Only committed packets are visible downstream, through a registered memory
// read that also serves as the output holding register.
module dpe_egress_pkt_fifo #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 32
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  // input stream from the demultiplexer
  input  logic                     from_demux_tvalid,
  output logic                     from_demux_tready,
  input  logic [127:0]             from_demux_tdata,
  input  logic [15:0]              from_demux_tkeep,
  input  logic                     from_demux_tlast,
  input  logic                     from_demux_tuser_bypass_all,
  input  logic                     from_demux_tuser_bypass_stage,
  input  logic [2:0]               from_demux_tuser_src,
  input  logic [2:0]               from_demux_tuser_dst,
  // output stream to the MAC
  output logic                     to_mac_tvalid,
  input  logic                     to_mac_tready,
  output logic [127:0]             to_mac_tdata,
  output logic [15:0]              to_mac_tkeep,
  output logic                     to_mac_tlast,
  output logic                     to_mac_tuser_bypass_all,
  output logic                     to_mac_tuser_bypass_stage,
  output logic [2:0]               to_mac_tuser_src,
  output logic [2:0]               to_mac_tuser_dst,
  // status
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         fwd_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = 128 + 16 + 1 + 8;

  logic [BW-1:0]    mem [DEPTH];
  logic [BW-1:0]    rd_data_reg;
  logic             out_valid_reg;

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    wr_commit_reg;
  logic [PW-1:0]    rd_ptr_reg;     // advances on output handshake; frees space
  logic [PW-1:0]    fetch_ptr_reg;  // advances when a beat is read into the output register
  logic             drop_reg;
  logic             tready_reg;
  logic             drop_pulse_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic [CNT_W-1:0] fwd_cnt_reg;

  logic [BW-1:0]    beat_in;
  logic [PW-1:0]    used;
  logic             full;
  logic             accept;
  logic             drop_now;
  logic             do_write;
  logic             commit;
  logic             rollback;
  logic             start_drop;
  logic             handshake;
  logic             avail;
  logic             fetch;

  assign beat_in = {from_demux_tdata, from_demux_tkeep, from_demux_tlast,
                    from_demux_tuser_bypass_all, from_demux_tuser_bypass_stage,
                    from_demux_tuser_src, from_demux_tuser_dst};

  // Occupancy is measured against rd_ptr, so a beat parked in the output
  // register still occupies its slot until the MAC takes it.
  assign used       = wr_ptr_reg - rd_ptr_reg;
  assign full       = (used == PW'(DEPTH));
  assign accept     = from_demux_tvalid & tready_reg;
  // A beat arriving at a full FIFO drops the packet, including this beat.
  assign drop_now   = drop_reg | full;
  assign do_write   = accept & ~drop_now;
  assign commit     = accept & from_demux_tlast & ~drop_now;
  assign rollback   = accept & from_demux_tlast & drop_now;
  assign start_drop = accept & ~from_demux_tlast & ~drop_reg & full;

  assign handshake  = out_valid_reg & to_mac_tready;
  assign avail      = (fetch_ptr_reg != wr_commit_reg);
  assign fetch      = avail & (~out_valid_reg | to_mac_tready);

  assign from_demux_tready = tready_reg;
  assign to_mac_tvalid     = out_valid_reg;
  assign {to_mac_tdata, to_mac_tkeep, to_mac_tlast,
          to_mac_tuser_bypass_all, to_mac_tuser_bypass_stage,
          to_mac_tuser_src, to_mac_tuser_dst} = rd_data_reg;
  assign drop_cnt   = drop_cnt_reg;
  assign fwd_cnt    = fwd_cnt_reg;
  assign level      = used;
  assign drop_pulse = drop_pulse_reg;

  // Storage array write port (no reset so it maps onto block RAM).
  always_ff @(posedge sys_clk) begin
    if (do_write) begin
      mem[wr_ptr_reg[AW-1:0]] <= beat_in;
    end
  end

  // Registered memory read doubling as the output holding register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      rd_data_reg <= '0;
    end else if (fetch) begin
      rd_data_reg <= mem[fetch_ptr_reg[AW-1:0]];
    end
  end

  // Output valid flag and read-side pointers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      out_valid_reg <= 1'b0;
      rd_ptr_reg    <= '0;
      fetch_ptr_reg <= '0;
    end else begin
      if (fetch) begin
        out_valid_reg <= 1'b1;
        fetch_ptr_reg <= fetch_ptr_reg + PW'(1);
      end else if (handshake) begin
        out_valid_reg <= 1'b0;
      end
      if (handshake) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

  // Write side: pointer advance, commit, drop/rollback and counters.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      tready_reg     <= 1'b0;
      wr_ptr_reg     <= '0;
      wr_commit_reg  <= '0;
      drop_reg       <= 1'b0;
      drop_pulse_reg <= 1'b0;
      drop_cnt_reg   <= '0;
      fwd_cnt_reg    <= '0;
    end else begin
      tready_reg     <= 1'b1;
      drop_pulse_reg <= rollback;
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (start_drop) begin
        drop_reg <= 1'b1;
      end
      if (commit) begin
        wr_commit_reg <= wr_ptr_reg + PW'(1);
        if (fwd_cnt_reg != '1) begin
          fwd_cnt_reg <= fwd_cnt_reg + CNT_W'(1);
        end
      end
      if (rollback) begin
        wr_ptr_reg <= wr_commit_reg;
        drop_reg   <= 1'b0;
        if (drop_cnt_reg != '1) begin
          drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dpe_egress_pkt_fifo.sv
// Scoreboard bench for dpe_egress_pkt_fifo with DEPTH=8.
module tb_dpe_egress_pkt_fifo;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  typedef logic [152:0] beat_t;

  logic           sys_clk = 1'b0;
  logic           sys_rst = 1'b0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic [127:0]   s_tdata = '0;
  logic [15:0]    s_tkeep = '0;
  logic           s_tlast = 1'b0;
  logic           s_ba = 1'b0;
  logic           s_bs = 1'b0;
  logic [2:0]     s_src = '0;
  logic [2:0]     s_dst = '0;
  logic           m_tvalid;
  logic           m_tready = 1'b0;
  logic [127:0]   m_tdata;
  logic [15:0]    m_tkeep;
  logic           m_tlast;
  logic           m_ba;
  logic           m_bs;
  logic [2:0]     m_src;
  logic [2:0]     m_dst;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fwd_cnt;
  logic [$clog2(DEPTH):0] level;
  logic           drop_pulse;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    pulse_seen = 0;
  bit    stall_prev = 0;
  beat_t stall_beat;
  bit    sender_done;

  always #5 sys_clk = ~sys_clk;

  dpe_egress_pkt_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .sys_clk                       (sys_clk),
    .sys_rst                       (sys_rst),
    .from_demux_tvalid             (s_tvalid),
    .from_demux_tready             (s_tready),
    .from_demux_tdata              (s_tdata),
    .from_demux_tkeep              (s_tkeep),
    .from_demux_tlast              (s_tlast),
    .from_demux_tuser_bypass_all   (s_ba),
    .from_demux_tuser_bypass_stage (s_bs),
    .from_demux_tuser_src          (s_src),
    .from_demux_tuser_dst          (s_dst),
    .to_mac_tvalid                 (m_tvalid),
    .to_mac_tready                 (m_tready),
    .to_mac_tdata                  (m_tdata),
    .to_mac_tkeep                  (m_tkeep),
    .to_mac_tlast                  (m_tlast),
    .to_mac_tuser_bypass_all       (m_ba),
    .to_mac_tuser_bypass_stage     (m_bs),
    .to_mac_tuser_src              (m_src),
    .to_mac_tuser_dst              (m_dst),
    .drop_cnt                      (drop_cnt),
    .fwd_cnt                       (fwd_cnt),
    .level                         (level),
    .drop_pulse                    (drop_pulse)
  );

  task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t out_beat();
    return {m_tdata, m_tkeep, m_tlast, m_ba, m_bs, m_src, m_dst};
  endfunction

  // Output monitor: stability on stalls, scoreboard pop on handshakes.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check_val("stall_valid", 160'(m_tvalid), 160'(1));
        check_val("stall_data", 160'(out_beat()), 160'(stall_beat));
      end
      if (m_tvalid && m_tready) begin
        check_val("beat_expected", 160'(exp_q.size() != 0), 160'(1));
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check_val("beat", 160'(out_beat()), 160'(e));
          $display("out beat %h last=%0d", out_beat(), m_tlast);
        end
      end
      stall_prev = m_tvalid && !m_tready;
      stall_beat = out_beat();
      if (drop_pulse) pulse_seen++;
    end
  end

  // Enter reset at the current time (posedge+1), verify reset state, release.
  task automatic do_reset();
    sys_rst  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    exp_q.delete();
    @(posedge sys_clk); #1;
    check_val("rst_tready", 160'(s_tready), 160'(0));
    check_val("rst_tvalid", 160'(m_tvalid), 160'(0));
    check_val("rst_data", 160'(out_beat()), 160'(0));
    check_val("rst_level", 160'(level), 160'(0));
    check_val("rst_drop_cnt", 160'(drop_cnt), 160'(0));
    check_val("rst_fwd_cnt", 160'(fwd_cnt), 160'(0));
    check_val("rst_pulse", 160'(drop_pulse), 160'(0));
    sys_rst = 1'b1;
    pulse_seen = 0;
    @(posedge sys_clk); #1;
    check_val("tready_up", 160'(s_tready), 160'(1));
  endtask

  // Present one random beat for one cycle; caller sits at posedge+1.
  task automatic drive_beat(input bit last, input bit keep_it);
    beat_t b;
    s_tvalid = 1'b1;
    s_tdata  = {$urandom, $urandom, $urandom, $urandom};
    s_tkeep  = last ? 16'($urandom_range(1, 16'hffff)) : 16'hffff;
    s_tlast  = last;
    {s_ba, s_bs, s_src, s_dst} = 8'($urandom);
    b = {s_tdata, s_tkeep, s_tlast, s_ba, s_bs, s_src, s_dst};
    if (keep_it) exp_q.push_back(b);
    @(posedge sys_clk); #1;
  endtask

  task automatic send_pkt(input int len, input bit keep_it);
    $display("send pkt len=%0d expect_kept=%0d", len, keep_it);
    for (int i = 0; i < len; i++) drive_beat(i == len - 1, keep_it);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check_val("drain", 160'(exp_q.size()), 160'(0));
    @(posedge sys_clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    idle(1);

    // 1: single 4-beat packet, latency and pass-through
    do_reset();
    m_tready = 1'b1;
    send_pkt(4, 1);
    check_val("lat_cycle1", 160'(m_tvalid), 160'(0));
    @(posedge sys_clk); #1;
    check_val("lat_cycle2", 160'(m_tvalid), 160'(1));
    wait_drain(20);
    check_val("t1_fwd", 160'(fwd_cnt), 160'(1));
    check_val("t1_level", 160'(level), 160'(0));

    // 2: 5-beat kept, 4-beat dropped while stalled
    do_reset();
    m_tready = 1'b0;
    send_pkt(5, 1);
    send_pkt(4, 0);
    idle(2);
    check_val("t2_level", 160'(level), 160'(5));
    check_val("t2_drop", 160'(drop_cnt), 160'(1));
    check_val("t2_fwd", 160'(fwd_cnt), 160'(1));
    check_val("t2_pulse", 160'(pulse_seen), 160'(1));
    m_tready = 1'b1;
    wait_drain(30);
    check_val("t2_level_end", 160'(level), 160'(0));

    // 3: exact fill commits, next 1-beat packet drops
    do_reset();
    m_tready = 1'b0;
    send_pkt(8, 1);
    idle(2);
    check_val("t3_level_full", 160'(level), 160'(8));
    check_val("t3_drop0", 160'(drop_cnt), 160'(0));
    check_val("t3_fwd", 160'(fwd_cnt), 160'(1));
    send_pkt(1, 0);
    idle(2);
    check_val("t3_drop1", 160'(drop_cnt), 160'(1));
    check_val("t3_pulse", 160'(pulse_seen), 160'(1));
    check_val("t3_level_keep", 160'(level), 160'(8));
    m_tready = 1'b1;
    wait_drain(30);

    // 4: oversize packet dropped even with reads enabled
    do_reset();
    m_tready = 1'b1;
    send_pkt(12, 0);
    idle(6);
    check_val("t4_drop", 160'(drop_cnt), 160'(1));
    check_val("t4_fwd", 160'(fwd_cnt), 160'(0));
    check_val("t4_level", 160'(level), 160'(0));
    check_val("t4_tvalid", 160'(m_tvalid), 160'(0));

    // 5: 50 back-to-back 3-beat packets with random backpressure
    do_reset();
    sender_done = 0;
    fork
      begin
        for (int p = 0; p < 50; p++) begin
          int n = 0;
          while (level > DEPTH - 3 && n < 200) begin
            @(posedge sys_clk); #1;
            n++;
          end
          check_val("t5_space", 160'(level <= DEPTH - 3), 160'(1));
          send_pkt(3, 1);
        end
        sender_done = 1;
      end
      begin
        while (!sender_done) begin
          m_tready = 1'($urandom_range(0, 1));
          @(posedge sys_clk); #1;
        end
        m_tready = 1'b1;
      end
    join
    wait_drain(200);
    check_val("t5_fwd", 160'(fwd_cnt), 160'(50));
    check_val("t5_drop", 160'(drop_cnt), 160'(0));
    check_val("t5_level", 160'(level), 160'(0));

    // 6: reset mid-packet with a stalled output beat
    do_reset();
    m_tready = 1'b0;
    send_pkt(2, 1);
    idle(3);
    check_val("t6_stalled", 160'(m_tvalid), 160'(1));
    for (int i = 0; i < 3; i++) drive_beat(0, 0);
    do_reset();
    check_val("t6_tvalid", 160'(m_tvalid), 160'(0));
    check_val("t6_level", 160'(level), 160'(0));
    m_tready = 1'b1;
    send_pkt(2, 1);
    wait_drain(20);
    check_val("t6_fwd", 160'(fwd_cnt), 160'(1));
    check_val("t6_drop", 160'(drop_cnt), 160'(0));
    check_val("t6_level_end", 160'(level), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
